serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, which sets the operand and result width in bits (minimum 2).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: request pulse; sampled only in IDLE.
REQ-005 SHALL have port a, input, WIDTH bits: minuend, captured when start is accepted.
REQ-006 SHALL have port b, input, WIDTH bits: subtrahend, captured when start is accepted.
REQ-007 SHALL have port bin, input, 1 bit: initial borrow-in, captured when start is accepted.
REQ-008 SHALL have port diff, output, WIDTH bits: result a - b - bin, modulo 2^WIDTH.
REQ-009 SHALL have port bout, output, 1 bit: final borrow-out of the MSB.
REQ-010 SHALL have port busy, output, 1 bit: high while in SHIFT or DONE.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse that marks diff and bout valid.

Function
REQ-012 SHALL implement an FSM with exactly three states: IDLE, SHIFT, DONE.
REQ-013 SHALL, in IDLE with start=1 at a rising edge: load a, b, bin into internal registers, clear the bit counter, and go to SHIFT.
REQ-014 SHALL, in each SHIFT cycle, feed the current LSBs of the a/b shift registers and the borrow flip-flop into one full-subtractor cell.
REQ-015 SHALL, on each SHIFT edge: shift the difference bit into the result register MSB-first (right shift), register the cell's borrow, shift a and b right, and increment the counter.
REQ-016 SHALL spend exactly WIDTH cycles in SHIFT, then go to DONE on the edge where the counter reaches WIDTH-1.
REQ-017 SHALL assert done for exactly one cycle, while in DONE, and return to IDLE on the next edge.
REQ-018 SHALL define latency as follows: start accepted at edge k gives done=1 during the cycle after edge k+WIDTH.
REQ-019 SHALL hold diff and bout stable from DONE until the next accepted start; diff SHALL NOT be valid mid-SHIFT.
REQ-020 SHALL ignore start while in SHIFT or DONE, with no capture and no effect on the operation in flight.
REQ-021 SHALL set bout=1 exactly when a < b + bin as unsigned values.
REQ-022 SHALL keep start held continuously high from restarting the block until it has returned to IDLE, i.e. one operation per WIDTH+2 cycles maximum.

Reset
REQ-023 SHALL, with rst_n=0 at a rising edge, force: state IDLE; diff=0; bout=0; busy=0; done=0; counter, shift registers and borrow flip-flop=0.
REQ-024 SHALL abort any in-flight operation on reset mid-SHIFT or mid-DONE, with no done pulse and no partial result visible.
REQ-025 SHALL ignore start while rst_n=0.

Configuration
REQ-026 SHALL, with macro SERIAL_SUB_OVF_EN defined, add port ovf, output, 1 bit: signed two's-complement overflow, (a_msb != b_msb) && (diff_msb != a_msb), valid with diff, reset 0.
REQ-027 SHALL, with SERIAL_SUB_OVF_EN undefined, omit the ovf port and its logic entirely, with all other behaviour identical.

Structure
REQ-028 SHALL place the state encoding constants (IDLE=0, SHIFT=1, DONE=2) and the default WIDTH in shared package serial_sub_pkg.
REQ-029 SHALL instantiate one combinational sub-module, fs_cell (inputs a, b, bin; outputs d, bo), for the per-bit full subtraction.
REQ-030 SHALL size the counter as clog2(WIDTH) bits.

Verification (WIDTH=8)
REQ-031 SHALL test a=0x05, b=0x03, bin=0 -> done 9 cycles after the start edge, diff=0x02, bout=0.
REQ-032 SHALL test a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1; a=0x10, b=0x0F, bin=1 -> diff=0x00, bout=0.
REQ-033 SHALL test a=0x80, b=0x01 with SERIAL_SUB_OVF_EN -> diff=0x7F, bout=0, ovf=1; a=0x7F, b=0x01 -> ovf=0.
REQ-034 SHALL test start, then a second start with new operands 3 cycles later -> exactly one done, with result from the first operands only.
REQ-035 SHALL test rst_n=0 for one cycle, 4 cycles into SHIFT -> busy=0, diff=0 and no done; a new start then completes normally.
REQ-036 SHALL test start held high for 20 cycles -> done pulses spaced exactly WIDTH+2 cycles apart, each one cycle wide.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared constants for the bit-serial subtractor: FSM state encodings and default width.
package serial_sub_pkg;

  localparam int SUB_WIDTH_DEF = 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

endpackage

// File: rtl/serial_subtractor_fs_cell.sv
// One-bit full subtractor: d = a - b - bin, bo = borrow out of this bit.
module fs_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bin;
  assign bo = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, one bit per clock LSB-first through a single fs_cell.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy,
  output logic             done
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int                CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_borrow;
  logic [CNT_W-1:0] r_cnt;
  logic             w_d;
  logic             w_bo;
`ifdef SERIAL_SUB_OVF_EN
  logic             r_ovf;
`endif

  fs_cell u_cell (
    .a   (r_a[0]),
    .b   (r_b[0]),
    .bin (r_borrow),
    .d   (w_d),
    .bo  (w_bo)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
`ifdef SERIAL_SUB_OVF_EN
      r_ovf    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= bin;
            r_cnt    <= '0;
            r_state  <= SHIFT;
          end
        end
        SHIFT: begin
          // Difference bits enter at the MSB so the first (LSB) bit lands at bit 0 after WIDTH shifts.
          r_res    <= {w_d, r_res[WIDTH-1:1]};
          r_borrow <= w_bo;
          r_a      <= {1'b0, r_a[WIDTH-1:1]};
          r_b      <= {1'b0, r_b[WIDTH-1:1]};
          r_cnt    <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) begin
            r_state <= DONE;
`ifdef SERIAL_SUB_OVF_EN
            // On the last bit r_a[0]/r_b[0] hold the original operand MSBs and w_d is the result MSB.
            r_ovf   <= (r_a[0] != r_b[0]) && (w_d != r_a[0]);
`endif
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign diff = r_res;
  assign bout = r_borrow;
  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8); ovf checks need SERIAL_SUB_OVF_EN.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             busy;
  logic             done;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .diff  (diff),
    .bout  (bout),
    .busy  (busy),
    .done  (done)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Presents operands at a falling edge; the following rising edge is the start edge.
  task automatic launch(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v, input logic tbin);
    @(negedge clk);
    a     = ta;
    b     = tb_v;
    bin   = tbin;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the falling edge just after the start edge; n counts falling edges until done is seen.
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) check("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                        input logic tbin, input logic [WIDTH-1:0] exp_d, input logic exp_bo,
                        input logic exp_ovf);
    int n;
    launch(ta, tb_v, tbin);
    wait_done(n);
    // Done is first sampled by the rising edge WIDTH+1 edges after the start edge.
    check({tag, "_latency"}, 32'(n + 1), 32'(WIDTH + 1));
    check({tag, "_diff"}, 32'(diff), 32'(exp_d));
    check({tag, "_bout"}, 32'(bout), 32'(exp_bo));
`ifdef SERIAL_SUB_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
`else
    if (exp_ovf === 1'bx) check({tag, "_ovf_arg"}, 32'(exp_ovf), 32'd0);
`endif
    @(negedge clk);
    check({tag, "_done_1cyc"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({tag, "_hold"}, 32'(diff), 32'(exp_d));
  endtask

  initial begin
    int n_done;
    int n_high;
    int first_pos;
    int second_pos;
    logic prev;
    logic [WIDTH-1:0] cap_d;
    logic cap_bo;

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);

    // Start asserted while reset is low must be ignored.
    a = 8'h12; b = 8'h34; start = 1'b1;
    @(negedge clk);
    check("rst_ignores_start", 32'(busy), 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    run_op("sub_05_03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    run_op("sub_00_01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    run_op("sub_10_0F_b1", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0);
    run_op("sub_80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    run_op("sub_7F_01", 8'h7F, 8'h01, 1'b0, 8'h7E, 1'b0, 1'b0);
    run_op("sub_00_FF_b1", 8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0);
    run_op("sub_FF_FF", 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0);

    // A second start 3 cycles into the operation must be ignored.
    launch(8'h33, 8'h11, 1'b0);
    repeat (2) @(negedge clk);
    a = 8'hAA; b = 8'h01; bin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("overlap_busy", 32'(busy), 32'd1);
    n_done = 0;
    cap_d  = '0;
    cap_bo = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (done === 1'b1) begin
        n_done++;
        cap_d  = diff;
        cap_bo = bout;
      end
      @(negedge clk);
    end
    check("overlap_done_count", 32'(n_done), 32'd1);
    check("overlap_diff", 32'(cap_d), 32'h22);
    check("overlap_bout", 32'(cap_bo), 32'd0);

    // Reset four cycles into SHIFT aborts the operation.
    launch(8'h44, 8'h22, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_bout", 32'(bout), 32'd0);
    n_done = 0;
    for (int i = 0; i < 15; i++) begin
      if (done === 1'b1) n_done++;
      @(negedge clk);
    end
    check("abort_no_done", 32'(n_done), 32'd0);
    run_op("after_abort", 8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0);

    // Start held high for 20 edges: operations back-to-back every WIDTH+2 cycles.
    @(negedge clk);
    a = 8'h20; b = 8'h05; bin = 1'b0; start = 1'b1;
    n_done     = 0;
    n_high     = 0;
    first_pos  = -1;
    second_pos = -1;
    prev       = 1'b0;
    cap_d      = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        n_high++;
        cap_d = diff;
        if (prev !== 1'b1) begin
          n_done++;
          if (first_pos < 0) first_pos = i;
          else if (second_pos < 0) second_pos = i;
        end
      end
      prev = done;
      if (i == 19) start = 1'b0;
    end
    check("held_pulses", 32'(n_done), 32'd2);
    check("held_width", 32'(n_high), 32'd2);
    check("held_first_pos", 32'(first_pos), 32'(WIDTH));
    check("held_spacing", 32'(second_pos - first_pos), 32'(WIDTH + 2));
    check("held_diff", 32'(cap_d), 32'h1B);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
